// File: rtl/mac_package.sv
`default_nettype none
// ============================================================================
// Module   : mac_package
// Purpose  : Shared constants and types for the MAC TCDM arbiter.
//            MAC_ARB_NR   - default number of requester ports
//            MAC_ARB_IDW  - width of a requester index
//            mac_arb_id_t - requester ID as stored in the outstanding FIFO
// Revision : 1.0 - initial release
// ============================================================================
package mac_package;

    localparam int MAC_ARB_NR  = 4;
    localparam int MAC_ARB_IDW = (MAC_ARB_NR > 1) ? $clog2(MAC_ARB_NR) : 1;

    typedef logic [MAC_ARB_IDW-1:0] mac_arb_id_t;

endpackage
`default_nettype wire

// File: rtl/mac_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mac_arb_id_fifo
// Purpose  : Small FIFO of requester IDs for granted transactions that are
//            still waiting for their response.
// Ports    : clk_i, rst_i (sync, active-high), clear_i (sync soft clear)
//            push_i / data_i  - enqueue (ignored while full)
//            pop_i  / data_o  - dequeue head (ignored while empty)
//            full_o, empty_o, count_o - registered occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module mac_arb_id_fifo #(
    parameter int FD    = 4,
    parameter int WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(FD):0]    count_o
);

    localparam int c_PW = $clog2(FD);
    localparam int c_CW = $clog2(FD) + 1;

    logic [WIDTH-1:0] r_mem [FD];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // Full blocks a push even when a pop happens the same cycle (no bypass).
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    assign full_o  = (r_count == c_CW'(FD));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rptr];

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_tcdm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_tcdm_arbiter
// Purpose  : Round-robin arbiter of NR requester streams onto one TCDM master
//            port, with in-order response routing via an outstanding-ID FIFO.
// Ports    : clk_i, rst_i (sync, active-high), clear_i (sync soft clear),
//            enable_i (arbitration enable)
//            requester side: req_i, gnt_o, add_i, wen_i, be_i, data_i,
//                            r_data_o (shared), r_valid_o (one-hot)
//            master side   : req_o, gnt_i, add_o, wen_o, be_o, data_o,
//                            r_data_i, r_valid_i
//            status        : busy_o, outstanding_o, err_o (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module mac_tcdm_arbiter
    import mac_package::*;
#(
    parameter int NR = MAC_ARB_NR,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int FD = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic [NR-1:0]              req_i,
    output logic [NR-1:0]              gnt_o,
    input  logic [NR-1:0][AW-1:0]      add_i,
    input  logic [NR-1:0]              wen_i,
    input  logic [NR-1:0][DW/8-1:0]    be_i,
    input  logic [NR-1:0][DW-1:0]      data_i,
    output logic [DW-1:0]              r_data_o,
    output logic [NR-1:0]              r_valid_o,
    output logic                       req_o,
    input  logic                       gnt_i,
    output logic [AW-1:0]              add_o,
    output logic                       wen_o,
    output logic [DW/8-1:0]            be_o,
    output logic [DW-1:0]              data_o,
    input  logic [DW-1:0]              r_data_i,
    input  logic                       r_valid_i,
    output logic                       busy_o,
    output logic [$clog2(FD):0]        outstanding_o,
    output logic                       err_o
);

    localparam int c_IDW = (NR > 1) ? $clog2(NR) : 1;

    logic [c_IDW-1:0]     r_ptr;
    logic                 r_err;
    logic [c_IDW-1:0]     w_win;
    logic                 w_any;
    int                   w_idx;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_IDW-1:0]     w_head;

    // Scan from the pointer, wrapping modulo NR; first requester wins.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NR; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NR) begin
                w_idx = w_idx - NR;
            end
            if (!w_any && req_i[w_idx[c_IDW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[c_IDW-1:0];
            end
        end
    end

    // Only the registered full flag gates the request, so responses never
    // reach req_o combinationally.
    assign req_o  = enable_i & w_any & ~w_full;
    assign w_hs   = req_o & gnt_i;

    assign add_o  = w_any ? add_i[w_win]  : '0;
    assign wen_o  = w_any ? wen_i[w_win]  : 1'b0;
    assign be_o   = w_any ? be_i[w_win]   : '0;
    assign data_o = w_any ? data_i[w_win] : '0;

    always_comb begin
        gnt_o = '0;
        if (w_hs) begin
            gnt_o[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            if (w_win == c_IDW'(NR - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + 1'b1;
            end
        end
    end

    mac_arb_id_fifo #(
        .FD    (FD),
        .WIDTH (c_IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .data_i  (w_win),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

    // Responses are routed regardless of enable_i.
    assign w_pop    = r_valid_i & ~w_empty;
    assign r_data_o = r_data_i;

    always_comb begin
        r_valid_o = '0;
        if (w_pop) begin
            r_valid_o[w_head] = 1'b1;
        end
    end

    // A response with nothing outstanding is a protocol error; held until cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_err <= 1'b0;
        end else if (r_valid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err_o  = r_err;
    assign busy_o = ~w_empty | req_o;

endmodule
`default_nettype wire

// File: tb/tb_mac_tcdm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tcdm_arbiter
// Purpose  : Self-checking bench for mac_tcdm_arbiter: directed vector table,
//            hand-written corner sequences and random traffic, all compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tcdm_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int BW = DW / 8;

    logic                    clk = 1'b0;
    logic                    rst_i, clear_i, enable_i;
    logic [NR-1:0]           req_i, gnt_o, wen_i, r_valid_o;
    logic [NR-1:0][AW-1:0]   add_i;
    logic [NR-1:0][BW-1:0]   be_i;
    logic [NR-1:0][DW-1:0]   data_i;
    logic [DW-1:0]           r_data_o, r_data_i, data_o;
    logic                    req_o, gnt_i, wen_o, r_valid_i, busy_o, err_o;
    logic [AW-1:0]           add_o;
    logic [BW-1:0]           be_o;
    logic [$clog2(FD):0]     outstanding_o;

    always #5 clk = ~clk;

    mac_tcdm_arbiter #(.NR(NR), .AW(AW), .DW(DW), .FD(FD)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
        .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o),
        .be_o(be_o), .data_o(data_o), .r_data_i(r_data_i), .r_valid_i(r_valid_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            m_ptr = 0;
    int            m_q[$];
    bit            m_err = 1'b0;
    bit            m_live = 1'b0;
    logic [NR-1:0] m_last_gnt = '0;

    // Outputs sampled just after the falling edge
    logic [NR-1:0] s_gnt, s_rvo;
    logic          s_req, s_busy, s_err;
    logic [2:0]    s_out;
    logic [DW-1:0] s_rdata;

    typedef struct {
        logic [NR-1:0] req;
        logic          gnt;
        logic          rv;
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rvo;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set(input logic [NR-1:0] r, input logic g, input logic v);
        req_i     = r;
        gnt_i     = g;
        r_valid_i = v;
    endtask

    // One clock: check outputs against the model, advance the model, step.
    task automatic cyc();
        int            win;
        int            idx;
        logic          e_req;
        logic [NR-1:0] e_gnt, e_rvo;
        #1;
        s_gnt = gnt_o; s_rvo = r_valid_o; s_req = req_o; s_busy = busy_o;
        s_err = err_o; s_out = outstanding_o; s_rdata = r_data_o;
        win = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (win < 0 && req_i[idx]) win = idx;
        end
        e_req = enable_i && (win >= 0) && (m_q.size() < FD);
        e_gnt = '0;
        if (e_req && gnt_i) e_gnt[win] = 1'b1;
        e_rvo = '0;
        if (r_valid_i && m_q.size() > 0) e_rvo[m_q[0]] = 1'b1;
        if (m_live) begin
            chk("req_o", req_o, e_req);
            chk("gnt_o", gnt_o, e_gnt);
            chk("add_o", add_o, (win >= 0) ? add_i[win] : '0);
            chk("wen_o", wen_o, (win >= 0) ? wen_i[win] : 1'b0);
            chk("be_o", be_o, (win >= 0) ? be_i[win] : '0);
            chk("data_o", data_o, (win >= 0) ? data_i[win] : '0);
            chk("r_valid_o", r_valid_o, e_rvo);
            chk("r_data_o", r_data_o, r_data_i);
            chk("busy_o", busy_o, (m_q.size() > 0) || e_req);
            chk("outstanding_o", outstanding_o, m_q.size());
            chk("err_o", err_o, m_err);
        end
        m_last_gnt = e_gnt;
        if (rst_i || (m_live && clear_i)) begin
            m_live = 1'b1;
            m_ptr  = 0;
            m_q.delete();
            m_err  = 1'b0;
        end else if (m_live) begin
            if (r_valid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (e_req && gnt_i) begin
                m_q.push_back(win);
                m_ptr = (win + 1) % NR;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set('0, 1'b0, 1'b0);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
        for (int i = 0; i < NR; i++) begin
            add_i[i] = 32'h1000_0000 + i; wen_i[i] = i[0];
            be_i[i] = 4'hF; data_i[i] = 32'hD000_0000 + i;
        end
        @(negedge clk);
        do_reset();

        // Reset state
        cyc();
        chk("reset_outstanding", s_out, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_err", s_err, 0);

        // All four requesting with grant tied high: rotating grants.
        tbl[0] = '{4'hF, 1'b1, 1'b0, 4'b0001, 4'b0000};
        tbl[1] = '{4'hF, 1'b1, 1'b1, 4'b0010, 4'b0001};
        tbl[2] = '{4'hF, 1'b1, 1'b1, 4'b0100, 4'b0010};
        tbl[3] = '{4'hF, 1'b1, 1'b1, 4'b1000, 4'b0100};
        tbl[4] = '{4'hF, 1'b1, 1'b1, 4'b0001, 4'b1000};
        tbl[5] = '{4'h0, 1'b0, 1'b1, 4'b0000, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            set(tbl[i].req, tbl[i].gnt, tbl[i].rv);
            cyc();
            chk("tbl_gnt", s_gnt, tbl[i].e_gnt);
            chk("tbl_rvalid", s_rvo, tbl[i].e_rvo);
        end

        // Stalled grant then pointer advance past the winner.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set(4'b0101, 1'b0, 1'b0); cyc();
            chk("stall_gnt", s_gnt, 0);
            chk("stall_req", s_req, 1);
        end
        set(4'b0101, 1'b1, 1'b0); cyc(); chk("stall_release_gnt", s_gnt, 4'b0001);
        set(4'b0101, 1'b1, 1'b1); cyc(); chk("after_ptr_gnt", s_gnt, 4'b0100);
        set(4'b0000, 1'b0, 1'b1); cyc(); chk("stall_drain_rvalid", s_rvo, 4'b0100);

        // FIFO full blocks requests; a pop re-opens them one cycle later.
        do_reset();
        for (int i = 0; i < 4; i++) begin set(4'hF, 1'b1, 1'b0); cyc(); end
        set(4'hF, 1'b1, 1'b0); cyc();
        chk("full_outstanding", s_out, 4);
        chk("full_req", s_req, 0);
        set(4'hF, 1'b1, 1'b1); cyc();
        chk("full_pop_req", s_req, 0);
        chk("full_pop_rvalid", s_rvo, 4'b0001);
        set(4'hF, 1'b1, 1'b0); cyc();
        chk("reopen_req", s_req, 1);
        chk("reopen_gnt", s_gnt, 4'b0001);
        for (int i = 0; i < 4; i++) begin set(4'h0, 1'b0, 1'b1); cyc(); end

        // In-order response routing with data.
        do_reset();
        set(4'b0100, 1'b1, 1'b0); cyc(); chk("route_g2", s_gnt, 4'b0100);
        set(4'b0001, 1'b1, 1'b0); cyc(); chk("route_g0", s_gnt, 4'b0001);
        set(4'b1000, 1'b1, 1'b0); cyc(); chk("route_g3", s_gnt, 4'b1000);
        set(4'b0000, 1'b0, 1'b1);
        r_data_i = 32'hA; cyc(); chk("route_rv2", s_rvo, 4'b0100); chk("route_dA", s_rdata, 32'hA);
        r_data_i = 32'hB; cyc(); chk("route_rv0", s_rvo, 4'b0001); chk("route_dB", s_rdata, 32'hB);
        r_data_i = 32'hC; cyc(); chk("route_rv3", s_rvo, 4'b1000); chk("route_dC", s_rdata, 32'hC);

        // Unexpected response sets the sticky error; clear restores everything.
        do_reset();
        set(4'b0010, 1'b1, 1'b0); cyc();
        set(4'b0000, 1'b0, 1'b1); cyc();
        set(4'b0000, 1'b0, 1'b1); cyc(); chk("err_no_rvalid", s_rvo, 0);
        set(4'b0000, 1'b0, 1'b0); cyc(); chk("err_set", s_err, 1);
        cyc(); chk("err_held", s_err, 1);
        clear_i = 1'b1; cyc(); clear_i = 1'b0;
        cyc();
        chk("clear_err", s_err, 0);
        chk("clear_outstanding", s_out, 0);
        set(4'hF, 1'b1, 1'b0); cyc(); chk("clear_ptr_gnt", s_gnt, 4'b0001);
        set(4'h0, 1'b0, 1'b1); cyc();

        // Reset with transactions outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) begin set(4'hF, 1'b1, 1'b0); cyc(); end
        do_reset();
        cyc();
        chk("rst_outstanding", s_out, 0);
        chk("rst_busy", s_busy, 0);
        set(4'hF, 1'b1, 1'b0); cyc(); chk("rst_first_gnt", s_gnt, 4'b0001);
        set(4'h0, 1'b0, 1'b1); cyc();

        // Random sticky traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_last_gnt[i] || (!req_i[i] && ($urandom % 10) < 4)) begin
                    req_i[i]  = ($urandom % 2) == 0;
                    add_i[i]  = $urandom;
                    wen_i[i]  = $urandom_range(1, 0);
                    be_i[i]   = 4'($urandom_range(15, 0));
                    data_i[i] = $urandom;
                end
            end
            enable_i  = ($urandom % 8) != 0;
            gnt_i     = ($urandom % 4) != 0;
            r_valid_i = (m_q.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 64 == 0);
            r_data_i  = $urandom;
            clear_i   = ($urandom % 200) == 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
